// File: rtl/micro_sequence_controller.sv
// Micro-sequence controller: decodes the sequencing field of the current
// microinstruction and issues the command/loadAddress pair to the micro-address
// counter. Holds the subroutine return stack and the single hardware loop counter.

package MicroAddress;
   typedef logic [7:0] Address;
   typedef enum logic [1:0] {
      noneCommand      = 2'd0,
      incrementCommand = 2'd1,
      loadCommand      = 2'd2,
      resetCommand     = 2'd3
   } Command;
   localparam Address addressIncrementStep = 8'd1;
endpackage

module micro_sequence_controller
   import MicroAddress::*;
#(
   parameter int STACK_DEPTH = 4,
   parameter int COUNT_WIDTH = 8,
   parameter int COND_COUNT  = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           stall,
   input  logic [2:0]                     seqOp,
   input  Address                         target,
   input  logic [COUNT_WIDTH-1:0]         countValue,
   input  logic [$clog2(COND_COUNT)-1:0]  condSelect,
   input  logic                           condPolarity,
   input  logic [COND_COUNT-1:0]          conditions,
   input  Address                         currentAddress,
   input  Address                         dispatchAddress,
   input  logic                           dispatchValid,
   output logic                           dispatchReady,
   output Command                         command,
   output Address                         loadAddress,
   output logic                           stackError,
   output logic [$clog2(STACK_DEPTH):0]   stackDepth
);

   localparam int SPW = $clog2(STACK_DEPTH);

   localparam logic [2:0] OP_NEXT     = 3'd0;
   localparam logic [2:0] OP_JUMP     = 3'd1;
   localparam logic [2:0] OP_BRANCH   = 3'd2;
   localparam logic [2:0] OP_CALL     = 3'd3;
   localparam logic [2:0] OP_RETURN   = 3'd4;
   localparam logic [2:0] OP_DISPATCH = 3'd5;
   localparam logic [2:0] OP_LOOP     = 3'd6;
   localparam logic [2:0] OP_SETCNT   = 3'd7;

   Address                  r_stack [STACK_DEPTH];
   logic [SPW:0]            r_sp;
   logic [COUNT_WIDTH-1:0]  r_loop_count;
   logic                    r_stack_error;

   logic                    w_full;
   logic                    w_empty;
   logic [SPW-1:0]          w_top_idx;
   Address                  w_return_addr;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_err_set;
   logic                    w_loop_dec;
   logic                    w_loop_load;

   assign w_full        = (r_sp == (SPW+1)'(STACK_DEPTH));
   assign w_empty       = (r_sp == '0);
   // Low bits of a full pointer are zero, so minus one lands on the last entry.
   assign w_top_idx     = r_sp[SPW-1:0] - SPW'(1);
   assign w_return_addr = currentAddress + addressIncrementStep;

   assign stackDepth = r_sp;
   assign stackError = r_stack_error;

   // Decode the sequencing op into the counter command and the state-update strobes.
   always_comb begin
      command       = noneCommand;
      loadAddress   = '0;
      dispatchReady = 1'b0;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_err_set     = 1'b0;
      w_loop_dec    = 1'b0;
      w_loop_load   = 1'b0;
      if (reset) begin
         command = resetCommand;
      end else if (!stall) begin
         case (seqOp)
            OP_NEXT: command = incrementCommand;
            OP_JUMP: begin
               command     = loadCommand;
               loadAddress = target;
            end
            OP_BRANCH: begin
               if (conditions[condSelect] == condPolarity) begin
                  command     = loadCommand;
                  loadAddress = target;
               end else begin
                  command = incrementCommand;
               end
            end
            OP_CALL: begin
               if (!w_full) begin
                  w_push      = 1'b1;
                  command     = loadCommand;
                  loadAddress = target;
               end else begin
                  w_err_set = 1'b1;
                  command   = resetCommand;
               end
            end
            OP_RETURN: begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  command     = loadCommand;
                  loadAddress = r_stack[w_top_idx];
               end else begin
                  w_err_set = 1'b1;
                  command   = resetCommand;
               end
            end
            OP_DISPATCH: begin
               // Without a valid entry point, hold the counter and retry next cycle.
               if (dispatchValid) begin
                  command       = loadCommand;
                  loadAddress   = dispatchAddress;
                  dispatchReady = 1'b1;
               end
            end
            OP_LOOP: begin
               if (r_loop_count != '0) begin
                  w_loop_dec  = 1'b1;
                  command     = loadCommand;
                  loadAddress = target;
               end else begin
                  command = incrementCommand;
               end
            end
            OP_SETCNT: begin
               w_loop_load = 1'b1;
               command     = incrementCommand;
            end
            default: command = noneCommand;
         endcase
      end
   end

   // Stack pointer, loop counter and sticky error; entries themselves are never cleared.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sp          <= '0;
         r_loop_count  <= '0;
         r_stack_error <= 1'b0;
      end else begin
         if (w_push)      r_sp          <= r_sp + (SPW+1)'(1);
         if (w_pop)       r_sp          <= r_sp - (SPW+1)'(1);
         if (w_err_set)   r_stack_error <= 1'b1;
         if (w_loop_dec)  r_loop_count  <= r_loop_count - COUNT_WIDTH'(1);
         if (w_loop_load) r_loop_count  <= countValue;
      end
   end

   // Return-address storage, written at the slot the pointer currently names.
   always_ff @(posedge clock) begin
      if (w_push) r_stack[r_sp[SPW-1:0]] <= w_return_addr;
   end

endmodule

// File: tb/tb_micro_sequence_controller.sv
// Bench for micro_sequence_controller: a directed vector table walking the main
// sequences, followed by random stimulus compared against a queue-based model.

module tb_micro_sequence_controller;
   import MicroAddress::*;

   logic         clock = 1'b0;
   logic         reset;
   logic         stall;
   logic [2:0]   seqOp;
   Address       target;
   logic [7:0]   countValue;
   logic [2:0]   condSelect;
   logic         condPolarity;
   logic [7:0]   conditions;
   Address       currentAddress;
   Address       dispatchAddress;
   logic         dispatchValid;
   logic         dispatchReady;
   Command       command;
   Address       loadAddress;
   logic         stackError;
   logic [2:0]   stackDepth;

   int checks = 0;
   int errors = 0;

   micro_sequence_controller #(.STACK_DEPTH(4), .COUNT_WIDTH(8), .COND_COUNT(8)) dut (
      .clock(clock), .reset(reset), .stall(stall), .seqOp(seqOp), .target(target),
      .countValue(countValue), .condSelect(condSelect), .condPolarity(condPolarity),
      .conditions(conditions), .currentAddress(currentAddress),
      .dispatchAddress(dispatchAddress), .dispatchValid(dispatchValid),
      .dispatchReady(dispatchReady), .command(command), .loadAddress(loadAddress),
      .stackError(stackError), .stackDepth(stackDepth)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic   rst;
      logic   stl;
      int     op;
      int     tgt;
      int     cnt;
      int     csel;
      int     cpol;
      int     cond;
      int     cur;
      int     dad;
      int     dv;
      Command ecmd;
      int     eaddr;
      int     erdy;
      int     edep;
      int     eerr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic stl, input int op, input int tgt,
                      input int cnt, input int csel, input int cpol, input int cond,
                      input int cur, input int dad, input int dv, input Command ecmd,
                      input int eaddr, input int erdy, input int edep, input int eerr);
      vec_t v;
      v = '{rst, stl, op, tgt, cnt, csel, cpol, cond, cur, dad, dv,
            ecmd, eaddr, erdy, edep, eerr};
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic stl, input int op, input int tgt,
                        input int cnt, input int csel, input int cpol, input int cond,
                        input int cur, input int dad, input int dv);
      reset           = rst;
      stall           = stl;
      seqOp           = 3'(op);
      target          = 8'(tgt);
      countValue      = 8'(cnt);
      condSelect      = 3'(csel);
      condPolarity    = 1'(cpol);
      conditions      = 8'(cond);
      currentAddress  = 8'(cur);
      dispatchAddress = 8'(dad);
      dispatchValid   = 1'(dv);
   endtask

   // Random phase reference state.
   Address m_stack[$];
   int     m_loop;
   bit     m_err;

   initial begin
      Command ecmd;
      int     eaddr, erdy;
      int     r_op, r_tgt, r_cnt, r_csel, r_cpol, r_cond, r_cur, r_dad, r_dv;
      logic   r_rst, r_stl;

      // op codes: 0 NEXT 1 JUMP 2 BRANCH 3 CALL 4 RETURN 5 DISPATCH 6 LOOP 7 SETCNT
      //   rst stl op tgt   cnt csel pol cond  cur   dad   dv  cmd               addr  rdy dep err
      add(1, 0, 1, 'h40, 0, 0, 0, 0,    0,    0,    0,  resetCommand,     0,    0,  0,  0);
      add(1, 0, 1, 'h40, 0, 0, 0, 0,    0,    0,    0,  resetCommand,     0,    0,  0,  0);
      add(0, 0, 0, 0,    0, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 3, 'h80, 0, 0, 0, 0,    'h10, 0,    0,  loadCommand,      'h80, 0,  0,  0);
      add(0, 0, 4, 0,    0, 0, 0, 0,    'h80, 0,    0,  loadCommand,      'h11, 0,  1,  0);
      add(0, 0, 0, 0,    0, 0, 0, 0,    'h11, 0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 3, 'h30, 0, 0, 0, 0,    'hFF, 0,    0,  loadCommand,      'h30, 0,  0,  0);
      add(0, 0, 4, 0,    0, 0, 0, 0,    'h30, 0,    0,  loadCommand,      'h00, 0,  1,  0);
      add(0, 0, 0, 0,    0, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 3, 'h50, 0, 0, 0, 0,    'h20, 0,    0,  loadCommand,      'h50, 0,  0,  0);
      add(0, 0, 3, 'h50, 0, 0, 0, 0,    'h20, 0,    0,  loadCommand,      'h50, 0,  1,  0);
      add(0, 0, 3, 'h50, 0, 0, 0, 0,    'h20, 0,    0,  loadCommand,      'h50, 0,  2,  0);
      add(0, 0, 3, 'h50, 0, 0, 0, 0,    'h20, 0,    0,  loadCommand,      'h50, 0,  3,  0);
      add(0, 0, 3, 'h50, 0, 0, 0, 0,    'h20, 0,    0,  resetCommand,     0,    0,  4,  0);
      add(0, 0, 0, 0,    0, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  4,  1);
      add(1, 0, 0, 0,    0, 0, 0, 0,    0,    0,    0,  resetCommand,     0,    0,  4,  1);
      add(0, 0, 4, 0,    0, 0, 0, 0,    0,    0,    0,  resetCommand,     0,    0,  0,  0);
      add(0, 0, 0, 0,    0, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  0,  1);
      add(1, 0, 0, 0,    0, 0, 0, 0,    0,    0,    0,  resetCommand,     0,    0,  0,  1);
      add(0, 0, 7, 0,    3, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  loadCommand,      'h20, 0,  0,  0);
      add(0, 0, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  loadCommand,      'h20, 0,  0,  0);
      add(0, 0, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  loadCommand,      'h20, 0,  0,  0);
      add(0, 0, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 5, 0,    0, 0, 0, 0,    0,    'h55, 0,  noneCommand,      0,    0,  0,  0);
      add(0, 0, 5, 0,    0, 0, 0, 0,    0,    'h55, 0,  noneCommand,      0,    0,  0,  0);
      add(0, 0, 5, 0,    0, 0, 0, 0,    0,    'h55, 0,  noneCommand,      0,    0,  0,  0);
      add(0, 0, 5, 0,    0, 0, 0, 0,    0,    'h55, 1,  loadCommand,      'h55, 1,  0,  0);
      add(0, 0, 0, 0,    0, 0, 0, 0,    0,    'h55, 1,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 2, 'h70, 0, 2, 0, 'h00, 0,    0,    0,  loadCommand,      'h70, 0,  0,  0);
      add(0, 0, 2, 'h70, 0, 2, 0, 'h04, 0,    0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 7, 0,    2, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 1, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  noneCommand,      0,    0,  0,  0);
      add(0, 1, 3, 'h20, 0, 0, 0, 0,    0,    0,    0,  noneCommand,      0,    0,  0,  0);
      add(0, 0, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  loadCommand,      'h20, 0,  0,  0);
      add(0, 0, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  loadCommand,      'h20, 0,  0,  0);
      add(0, 0, 6, 'h20, 0, 0, 0, 0,    0,    0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 0, 3, 'h60, 0, 0, 0, 0,    'h40, 0,    0,  loadCommand,      'h60, 0,  0,  0);
      add(0, 1, 4, 0,    0, 0, 0, 0,    'h60, 0,    1,  noneCommand,      0,    0,  1,  0);
      add(0, 0, 4, 0,    0, 0, 0, 0,    'h60, 0,    0,  loadCommand,      'h41, 0,  1,  0);
      add(0, 0, 0, 0,    0, 0, 0, 0,    'h41, 0,    0,  incrementCommand, 0,    0,  0,  0);
      add(0, 1, 5, 0,    0, 0, 0, 0,    0,    'h33, 1,  noneCommand,      0,    0,  0,  0);
      add(0, 0, 2, 'h9A, 0, 7, 1, 'h80, 0,    0,    0,  loadCommand,      'h9A, 0,  0,  0);

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clock);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].stl, tbl[i].op, tbl[i].tgt, tbl[i].cnt, tbl[i].csel,
               tbl[i].cpol, tbl[i].cond, tbl[i].cur, tbl[i].dad, tbl[i].dv);
         #4;
         chk($sformatf("vec%0d command", i), int'(command), int'(tbl[i].ecmd));
         chk($sformatf("vec%0d loadAddress", i), int'(loadAddress), tbl[i].eaddr);
         chk($sformatf("vec%0d dispatchReady", i), int'(dispatchReady), tbl[i].erdy);
         chk($sformatf("vec%0d stackDepth", i), int'(stackDepth), tbl[i].edep);
         chk($sformatf("vec%0d stackError", i), int'(stackError), tbl[i].eerr);
         @(posedge clock);
         #1;
      end

      // Random phase: first cycle is a reset so the model starts from a known state.
      m_stack.delete();
      m_loop = 0;
      m_err  = 0;
      for (int n = 0; n < 3000; n++) begin
         r_rst  = (n == 0) || ($urandom_range(0, 99) == 0);
         r_stl  = ($urandom_range(0, 7) == 0);
         r_op   = $urandom_range(0, 7);
         r_tgt  = $urandom_range(0, 255);
         r_cnt  = $urandom_range(0, 4);
         r_csel = $urandom_range(0, 7);
         r_cpol = $urandom_range(0, 1);
         r_cond = $urandom_range(0, 255);
         r_cur  = $urandom_range(0, 255);
         r_dad  = $urandom_range(0, 255);
         r_dv   = $urandom_range(0, 1);
         drive(r_rst, r_stl, r_op, r_tgt, r_cnt, r_csel, r_cpol, r_cond, r_cur, r_dad, r_dv);

         ecmd  = noneCommand;
         eaddr = 0;
         erdy  = 0;
         if (r_rst) ecmd = resetCommand;
         else if (!r_stl) begin
            case (r_op)
               0: ecmd = incrementCommand;
               1: begin ecmd = loadCommand; eaddr = r_tgt; end
               2: if (((r_cond >> r_csel) & 1) == r_cpol) begin
                     ecmd = loadCommand; eaddr = r_tgt;
                  end else ecmd = incrementCommand;
               3: if (m_stack.size() < 4) begin ecmd = loadCommand; eaddr = r_tgt; end
                  else ecmd = resetCommand;
               4: if (m_stack.size() > 0) begin ecmd = loadCommand; eaddr = int'(m_stack[$]); end
                  else ecmd = resetCommand;
               5: if (r_dv != 0) begin ecmd = loadCommand; eaddr = r_dad; erdy = 1; end
               6: if (m_loop != 0) begin ecmd = loadCommand; eaddr = r_tgt; end
                  else ecmd = incrementCommand;
               default: ecmd = incrementCommand;
            endcase
         end

         #4;
         chk($sformatf("rnd%0d command", n), int'(command), int'(ecmd));
         chk($sformatf("rnd%0d loadAddress", n), int'(loadAddress), eaddr);
         chk($sformatf("rnd%0d dispatchReady", n), int'(dispatchReady), erdy);
         chk($sformatf("rnd%0d stackDepth", n), int'(stackDepth), m_stack.size());
         chk($sformatf("rnd%0d stackError", n), int'(stackError), int'(m_err));

         if (r_rst) begin
            m_stack.delete();
            m_loop = 0;
            m_err  = 0;
         end else if (!r_stl) begin
            case (r_op)
               3: if (m_stack.size() < 4) m_stack.push_back(Address'((r_cur + 1) % 256));
                  else m_err = 1;
               4: if (m_stack.size() > 0) void'(m_stack.pop_back());
                  else m_err = 1;
               6: if (m_loop != 0) m_loop = m_loop - 1;
               7: m_loop = r_cnt;
               default: ;
            endcase
         end
         @(posedge clock);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/micro_sequence_controller.md
Name: micro_sequence_controller

Overview:
- Issuing side of the micro-address counter interface.
- Decodes the sequencing field of the current microinstruction, together with condition flags and the instruction-decoder dispatch handshake.
- Produces the MicroAddress::Command / loadAddress pair consumed by the counter each cycle.
- Owns the micro-subroutine return stack and the hardware loop counter.

Parameters:
STACK_DEPTH, 4, return-stack entries (power of two, >=2)
COUNT_WIDTH, 8, loop-counter width
COND_COUNT, 8, number of condition inputs (power of two)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high
stall  in  1  freeze sequencing this cycle
seqOp  in  3  sequencing operation of current microinstruction
target  in  MicroAddress::Address  branch/call/loop target
countValue  in  COUNT_WIDTH  immediate for SETCNT
condSelect  in  log2(COND_COUNT)  condition index for BRANCH
condPolarity  in  1  BRANCH taken when conditions[condSelect]==condPolarity
conditions  in  COND_COUNT  status flags
currentAddress  in  MicroAddress::Address  counter's present address
dispatchAddress  in  MicroAddress::Address  entry point from instruction decoder
dispatchValid  in  1  dispatchAddress valid
dispatchReady  out  1  dispatch accepted this cycle
command  out  MicroAddress::Command  to counter
loadAddress  out  MicroAddress::Address  to counter
stackError  out  1  sticky over/underflow flag
stackDepth  out  log2(STACK_DEPTH)+1  occupied stack entries

Behaviour:
- Reset is synchronous, active-high, on clock.
- Outputs are combinational from inputs and registered state. The counter registers them on the same edge, so a decision made in cycle N takes effect at the address in cycle N+1.
- Priority: reset > stall > seqOp.
- While reset is high:
  - command=resetCommand, loadAddress=0, dispatchReady=0.
  - On the edge: stack pointer=0, loopCounter=0, stackError=0.
- While stall is high (reset low):
  - command=noneCommand, loadAddress=0, dispatchReady=0.
  - No state change.
- loadAddress=0 whenever command is not loadCommand.
- seqOp encoding:
  - 0 NEXT: incrementCommand.
  - 1 JUMP: loadCommand, loadAddress=target.
  - 2 BRANCH: if conditions[condSelect]==condPolarity then loadCommand to target, else incrementCommand.
  - 3 CALL:
    - Stack not full: push currentAddress+addressIncrementStep (wraps modulo address width), loadCommand to target.
    - Stack full: no push, stackError<=1, command=resetCommand.
  - 4 RETURN:
    - Stack not empty: loadCommand, loadAddress=top entry; pop on edge.
    - Empty: stackError<=1, resetCommand.
  - 5 DISPATCH:
    - dispatchValid=1: loadCommand to dispatchAddress, dispatchReady=1 (single cycle).
    - dispatchValid=0: noneCommand (hold, retry next cycle), dispatchReady=0.
  - 6 LOOP:
    - loopCounter!=0: loopCounter<=loopCounter-1, loadCommand to target.
    - loopCounter==0: incrementCommand, counter stays 0.
  - 7 SETCNT: loopCounter<=countValue, incrementCommand.
- Loop counter is a single register. Nested loops must save it in microcode; it is not stacked.
- stackError is sticky until reset. It does not block later ops; only the faulting cycle is forced to resetCommand.
- stackDepth reflects the registered pointer; it equals STACK_DEPTH when full.
- dispatchReady is asserted only for DISPATCH with dispatchValid=1, never during reset or stall.
- Stack entries are not cleared on reset; only the pointer resets.

Test Plan:
- Reset held 2 cycles with seqOp=JUMP, target=0x40 -> command=resetCommand, loadAddress=0, stackDepth=0, stackError=0. Release with seqOp=NEXT -> incrementCommand.
- currentAddress=0x10, CALL target=0x80; next cycle currentAddress=0x80, RETURN -> first loadCommand/0x80, stackDepth 1; then loadCommand/0x11, stackDepth 0. Also CALL at currentAddress=max -> pushed value 0x00.
- STACK_DEPTH=4: five consecutive CALLs -> first four loadCommand, fifth resetCommand, stackError=1, stackDepth=4. RETURN on empty stack after reset -> resetCommand, stackError=1.
- SETCNT countValue=3, then LOOP target=0x20 repeated -> three loadCommand/0x20 cycles, then incrementCommand, loopCounter=0.
- DISPATCH with dispatchValid=0 for 3 cycles then 1 with dispatchAddress=0x55 -> noneCommand x3, then loadCommand/0x55 with dispatchReady=1 for exactly one cycle.
- BRANCH condSelect=2, condPolarity=0 with conditions[2]=0 -> loadCommand to target; with conditions[2]=1 -> incrementCommand. stall=1 during any op -> noneCommand, loopCounter and stack unchanged.
